// File: rtl/dmem_target.sv
// dmem_target: single-outstanding data-memory responder for the core's
// load/store port. Requests are accepted over valid/ready. After
// WAIT_STATES cycles the access commits. The registered result is then held
// on the response channel until the requester takes it.
module dmem_target #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [3:0]  i_req_be,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err
);

   localparam int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_INIT   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   // Access that commits on this edge (captured request, or the live one when
   // there are no wait states).
   logic             commit_s;
   logic             c_we_s;
   logic [31:0]      c_addr_s;
   logic [31:0]      c_wdata_s;
   logic [3:0]       c_be_s;
   logic [IDX_W-1:0] c_idx_s;
   logic             c_bad_s;
   logic             accept_s;
   logic             mem_we_s;

   assign o_req_ready = (state_q == ST_IDLE) && !i_rst;
   assign accept_s    = i_req_valid && o_req_ready;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rdata_q;
   assign o_rsp_err   = err_q;

   // Next-state, capture and commit logic for the request/response FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rsp_valid_d = rsp_valid_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      commit_s    = 1'b0;
      c_we_s      = we_q;
      c_addr_s    = addr_q;
      c_wdata_s   = wdata_q;
      c_be_s      = be_q;

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               we_d    = i_req_we;
               addr_d  = i_req_addr;
               wdata_d = i_req_wdata;
               be_d    = i_req_be;
               if (WAIT_STATES == 0) begin
                  state_d   = ST_RESP;
                  commit_s  = 1'b1;
                  c_we_s    = i_req_we;
                  c_addr_s  = i_req_addr;
                  c_wdata_s = i_req_wdata;
                  c_be_s    = i_req_be;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d  = ST_RESP;
               commit_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (i_rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               rdata_d     = 32'd0;
               err_d       = 1'b0;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase

      c_idx_s = c_addr_s[IDX_W+1:2];
      c_bad_s = (c_addr_s[1:0] != 2'd0) || (c_addr_s[31:2] >= DEPTH_LIMIT);

      if (commit_s) begin
         rsp_valid_d = 1'b1;
         if (c_bad_s) begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
         end else begin
            err_d   = 1'b0;
            rdata_d = c_we_s ? 32'd0 : mem_q[c_idx_s];
         end
      end else begin
         rsp_valid_d = rsp_valid_d;
      end

      mem_we_s = commit_s && !c_bad_s && c_we_s && !i_rst;
   end

   // FSM and response registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         be_q        <= 4'd0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   // Byte-lane store into the array; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (mem_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (c_be_s[i]) begin
               mem_q[c_idx_s][8*i +: 8] <= c_wdata_s[8*i +: 8];
            end
         end
      end
   end

endmodule
